// File: rtl/instr_encoder_if.sv
// Request/response bundle between a program sequencer and instr_encoder.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid & ready are both high. The producer keeps valid and its payload
// steady until that edge. ready never depends on valid in the same cycle.
interface instr_encoder_if #(
    parameter int AW = 12
);
    // request channel: sequencer -> encoder
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [19:0]   in_imm;

    // word channel: encoder -> instruction memory
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [AW-1:0] out_addr;

    // sequencer / memory side
    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_data, out_addr
    );

    // encoder side
    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs mnemonic-level requests into 32-bit words,
// queues them in a small FIFO and presents each with a sequential word address.
// Illegal operation codes complete their handshake but are only counted.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_encoder_if.slave         bus,
    input  logic                   base_load,
    input  logic [AW-1:0]          base_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             err_cnt
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_U,
        FMT_CSR,
        FMT_BAD
    } fmt_t;

    fmt_t        fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] word;
    logic        legal;

    logic [31:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   occ;
    logic [AW-1:0] addr;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;

    // Decode the operation code into an encoding format and funct fields.
    always_comb begin
        fmt = FMT_BAD;
        f3  = 3'b000;
        f7  = 7'b0000000;
        case (bus.in_op)
            5'd0:  begin fmt = FMT_R;   f3 = 3'b000; f7 = 7'b0000000; end
            5'd1:  begin fmt = FMT_R;   f3 = 3'b000; f7 = 7'b0100000; end
            5'd2:  begin fmt = FMT_R;   f3 = 3'b001; end
            5'd3:  begin fmt = FMT_R;   f3 = 3'b010; end
            5'd4:  begin fmt = FMT_R;   f3 = 3'b011; end
            5'd5:  begin fmt = FMT_R;   f3 = 3'b100; end
            5'd6:  begin fmt = FMT_R;   f3 = 3'b101; end
            5'd7:  begin fmt = FMT_R;   f3 = 3'b101; f7 = 7'b0100000; end
            5'd8:  begin fmt = FMT_R;   f3 = 3'b110; end
            5'd9:  begin fmt = FMT_R;   f3 = 3'b111; end
            5'd10: begin fmt = FMT_R;   f3 = 3'b000; f7 = 7'b0000001; end
            5'd11: begin fmt = FMT_R;   f3 = 3'b001; f7 = 7'b0000001; end
            5'd12: begin fmt = FMT_R;   f3 = 3'b011; f7 = 7'b0000001; end
            5'd13: begin fmt = FMT_I;   f3 = 3'b000; end
            5'd14: begin fmt = FMT_I;   f3 = 3'b100; end
            5'd15: begin fmt = FMT_I;   f3 = 3'b110; end
            5'd16: begin fmt = FMT_I;   f3 = 3'b111; end
            5'd17: begin fmt = FMT_SH;  f3 = 3'b001; end
            5'd18: begin fmt = FMT_SH;  f3 = 3'b101; end
            5'd19: begin fmt = FMT_SH;  f3 = 3'b101; f7 = 7'b0100000; end
            5'd20: begin fmt = FMT_U;   end
            5'd21: begin fmt = FMT_CSR; f3 = 3'b001; end
            default: fmt = FMT_BAD;
        endcase
    end

    // Assemble the word; only the fields a format uses are placed in it.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (fmt)
            FMT_R:   word = {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011};
            FMT_I:   word = {bus.in_imm[11:0], bus.in_rs1, f3, bus.in_rd, 7'b0010011};
            FMT_SH:  word = {f7, bus.in_imm[4:0], bus.in_rs1, f3, bus.in_rd, 7'b0010011};
            FMT_U:   word = {bus.in_imm, bus.in_rd, 7'b0110111};
            FMT_CSR: word = {bus.in_imm[11:0], bus.in_rs1, f3, bus.in_rd, 7'b1110011};
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    // Handshake qualifiers. A pop cannot free space for a push in the same
    // cycle, and an empty FIFO cannot pop, so there is no bypass path.
    always_comb begin
        full         = (occ == (PW+1)'(DEPTH));
        empty        = (occ == '0);
        bus.in_ready = !full && !rst;
        accept       = bus.in_valid && bus.in_ready;
        push         = accept && legal;
        bus.out_valid = !empty;
        pop          = bus.out_valid && bus.out_ready;
        bus.out_data = empty ? 32'd0 : mem[rd_ptr];
        bus.out_addr = addr;
        count        = occ;
    end

    // FIFO storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    // Pointers and occupancy of the circular buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                occ <= occ + (PW+1)'(1);
            end else if (pop && !push) begin
                occ <= occ - (PW+1)'(1);
            end
        end
    end

    // Word address of the head: a load overrides the post-pop increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (base_load) begin
            addr <= base_addr;
        end else if (pop) begin
            addr <= addr + AW'(1);
        end
    end

    // Count accepted illegal requests, holding at the top value.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && !legal && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule
